// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    ACCEPT  = 3'd2,
    WAITRDY = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] GNT_C0 = 2'd0;
  localparam logic [1:0] GNT_C1 = 2'd1;
  localparam logic [1:0] GNT_DL = 2'd2;

  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin select between the tile and sprite clients.
module sdram_rr_pick
  import sdram_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt_id,
  output logic       valid
);

  // On a tie the client that was not served last wins.
  always_comb begin
    gnt_id = GNT_C0;
    valid  = 1'b0;
    case ({req1, req0})
      2'b01: begin
        gnt_id = GNT_C0;
        valid  = 1'b1;
      end
      2'b10: begin
        gnt_id = GNT_C1;
        valid  = 1'b1;
      end
      2'b11: begin
        gnt_id = last ? GNT_C0 : GNT_C1;
        valid  = 1'b1;
      end
      default: begin
        gnt_id = GNT_C0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one byte-wide SDRAM controller port between the ROM download writer
// and two read clients, one transaction at a time.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW      = 25,
  parameter int DW      = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_wait,
  input  logic          c0_req,
  input  logic [AW-1:0] c0_addr,
  output logic [DW-1:0] c0_data,
  output logic          c0_ack,
  input  logic          c1_req,
  input  logic [AW-1:0] c1_addr,
  output logic [DW-1:0] c1_data,
  output logic          c1_ack,
  output logic [AW-1:0] sd_addr,
  output logic [DW-1:0] sd_din,
  output logic          sd_rd,
  output logic          sd_we,
  input  logic [DW-1:0] sd_dout,
  input  logic          sd_ready,
  output logic          err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state_r;
  logic [1:0]    gnt_r;
  logic          ptr_r;        // client preferred on the next tie
  logic          pend_r;
  logic [AW-1:0] hold_addr_r;
  logic [DW-1:0] hold_data_r;
  logic [CW-1:0] cnt_r;

  logic [1:0]    pick_gnt_s;
  logic          pick_valid_s;
  logic          rdy_hit_s;
  logic          to_hit_s;
  logic [DW-1:0] end_data_s;

  sdram_rr_pick u_pick (
    .req0   (c0_req),
    .req1   (c1_req),
    .last   (~ptr_r),
    .gnt_id (pick_gnt_s),
    .valid  (pick_valid_s)
  );

  // Completion conditions: controller result, or the wait budget used up.
  always_comb begin
    rdy_hit_s  = 1'b0;
    to_hit_s   = 1'b0;
    end_data_s = {DW{1'b1}};
    if (state_r == WAITRDY && sd_ready) begin
      rdy_hit_s = 1'b1;
    end else begin
      rdy_hit_s = 1'b0;
    end
    if ((state_r == ACCEPT || state_r == WAITRDY) && !rdy_hit_s && cnt_r == TO_LAST) begin
      to_hit_s = 1'b1;
    end else begin
      to_hit_s = 1'b0;
    end
    if (rdy_hit_s) begin
      end_data_s = sd_dout;
    end else begin
      end_data_s = {DW{1'b1}};
    end
  end

  // Download capture, transaction sequencer and all registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r     <= IDLE;
      gnt_r       <= GNT_C0;
      ptr_r       <= 1'b0;
      pend_r      <= 1'b0;
      hold_addr_r <= {AW{1'b0}};
      hold_data_r <= {DW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      dl_wait     <= 1'b0;
      c0_data     <= {DW{1'b0}};
      c1_data     <= {DW{1'b0}};
      c0_ack      <= 1'b0;
      c1_ack      <= 1'b0;
      sd_addr     <= {AW{1'b0}};
      sd_din      <= {DW{1'b0}};
      sd_rd       <= 1'b0;
      sd_we       <= 1'b0;
      err         <= 1'b0;
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      sd_rd  <= 1'b0;
      sd_we  <= 1'b0;

      if (dl_wr) begin
        if (pend_r) begin
          err <= 1'b1;
        end else begin
          hold_addr_r <= dl_addr;
          hold_data_r <= dl_data;
          pend_r      <= 1'b1;
          dl_wait     <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (sd_ready && pend_r) begin
            gnt_r   <= GNT_DL;
            sd_addr <= hold_addr_r;
            sd_din  <= hold_data_r;
            sd_we   <= 1'b1;
            state_r <= ISSUE;
          end else if (sd_ready && !dl_active && pick_valid_s) begin
            gnt_r   <= pick_gnt_s;
            ptr_r   <= (pick_gnt_s == GNT_C0);
            sd_addr <= (pick_gnt_s == GNT_C1) ? c1_addr : c0_addr;
            sd_rd   <= 1'b1;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_r   <= {CW{1'b0}};
          state_r <= ACCEPT;
        end
        ACCEPT, WAITRDY: begin
          if (rdy_hit_s || to_hit_s) begin
            if (to_hit_s) begin
              err <= 1'b1;
            end
            if (gnt_r == GNT_C0) begin
              c0_data <= end_data_s;
              c0_ack  <= 1'b1;
            end else if (gnt_r == GNT_C1) begin
              c1_data <= end_data_s;
              c1_ack  <= 1'b1;
            end
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (state_r == ACCEPT && !sd_ready) begin
              state_r <= WAITRDY;
            end
          end
        end
        DONE: begin
          if (gnt_r == GNT_DL) begin
            pend_r  <= 1'b0;
            dl_wait <= 1'b0;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, corner-case
// sequences and a randomized client phase against a behavioural model.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 8;
  localparam int TO = 255;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [DW-1:0] dl_data = '0;
  logic          dl_wait;
  logic          c0_req = 1'b0;
  logic [AW-1:0] c0_addr = '0;
  logic [DW-1:0] c0_data;
  logic          c0_ack;
  logic          c1_req = 1'b0;
  logic [AW-1:0] c1_addr = '0;
  logic [DW-1:0] c1_data;
  logic          c1_ack;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_din;
  logic          sd_rd;
  logic          sd_we;
  logic [DW-1:0] sd_dout = '0;
  logic          sd_ready = 1'b1;
  logic          err;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_data(c0_data), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_data(c1_data), .c1_ack(c1_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_rd(sd_rd), .sd_we(sd_we),
    .sd_dout(sd_dout), .sd_ready(sd_ready), .err(err)
  );

  int total = 0;
  int bad = 0;
  int ctl_busy = 3;
  bit ctl_stuck = 1'b0;
  bit rand_mode = 1'b0;
  int busy = 0;
  bit hung = 1'b0;
  logic [AW-1:0] lat_addr = '0;
  int pref = 0;

  // Contents of the model SDRAM: a fixed hash of the address.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h78;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Controller model: busy for a while after each command, then ready with data.
  always @(negedge clk_sys) begin
    if (sd_rd || sd_we) begin
      busy     = rand_mode ? int'($urandom_range(2, 6)) : ctl_busy;
      hung     = ctl_stuck;
      lat_addr = sd_addr;
    end else if (busy > 0) begin
      busy--;
    end
    if (!ctl_stuck) hung = 1'b0;
    sd_ready = (busy == 0) && !hung;
    sd_dout  = (busy == 0) ? mem_byte(lat_addr) : 8'h00;
  end

  task automatic check_reset_outs(input string nm);
    chk({nm, "_ctrl"}, {26'd0, sd_rd, sd_we, c0_ack, c1_ack, dl_wait, err}, 32'd0);
    chk({nm, "_data"}, {8'd0, c0_data, c1_data, sd_din}, 32'd0);
    chk({nm, "_addr"}, {7'd0, sd_addr}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    pref = 0;
    @(negedge clk_sys);
  endtask

  task automatic do_read(input string nm, input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1,
                         input int b, input int eg, input logic [7:0] ed);
    int rd_k, ack_k, rd_n;
    logic [AW-1:0] rd_a;
    logic [1:0] acks;
    logic [7:0] ad;
    rd_k = -1; ack_k = -1; rd_n = 0; acks = 2'b00; ad = 8'h00; rd_a = '0;
    ctl_busy = b;
    c0_req = r0; c0_addr = a0; c1_req = r1; c1_addr = a1;
    for (int k = 1; k <= 40 && ack_k < 0; k++) begin
      @(negedge clk_sys);
      if (sd_rd) begin
        rd_n++;
        if (rd_k < 0) begin rd_k = k; rd_a = sd_addr; end
      end
      if (c0_ack || c1_ack) begin
        ack_k = k; acks = {c1_ack, c0_ack}; ad = c1_ack ? c1_data : c0_data;
        c0_req = 1'b0; c1_req = 1'b0;
      end
    end
    c0_req = 1'b0; c1_req = 1'b0;
    chk({nm, "_rd_latency"}, rd_k, 1);
    chk({nm, "_addr"}, {7'd0, rd_a}, {7'd0, (eg == 0) ? a0 : a1});
    chk({nm, "_ack_latency"}, ack_k - rd_k, b + 1);
    chk({nm, "_ack_who"}, {30'd0, acks}, (eg == 0) ? 32'd1 : 32'd2);
    chk({nm, "_data"}, {24'd0, ad}, {24'd0, ed});
    chk({nm, "_rd_count"}, rd_n, 1);
    @(negedge clk_sys);
    chk({nm, "_ack_pulse"}, {30'd0, c1_ack, c0_ack}, 32'd0);
    repeat (2) @(negedge clk_sys);
    pref = (eg == 0) ? 1 : 0;
  endtask

  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    int            b;
    int            g;
    logic [7:0]    d;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    int n, who, we_n, we_k, low_k, rd_n, ack_n, rd_k, ack_k, got, og, g, nack;
    bit outst;
    logic [AW-1:0] aa[2];
    logic rq[2];
    logic [AW-1:0] ra[2];

    tbl[0] = '{1'b1, 25'h0000123, 1'b0, 25'h0000000, 3, 0, 8'h5A};
    tbl[1] = '{1'b0, 25'h0000000, 1'b1, 25'h000ABCD, 3, 1, 8'h1E};
    tbl[2] = '{1'b1, 25'h1000055, 1'b1, 25'h0000077, 4, 0, 8'h2D};
    tbl[3] = '{1'b1, 25'h0000011, 1'b1, 25'h0FF0022, 2, 1, 8'hA5};
    tbl[4] = '{1'b1, 25'h1FFFFFF, 1'b0, 25'h0000000, 2, 0, 8'h87};
    tbl[5] = '{1'b1, 25'h0000000, 1'b1, 25'h0000000, 6, 1, 8'h78};

    repeat (3) @(negedge clk_sys);
    check_reset_outs("reset_state");
    reset = 1'b0;
    @(negedge clk_sys);

    for (int i = 0; i < 6; i++)
      do_read($sformatf("vec%0d", i), tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1,
              tbl[i].b, tbl[i].g, tbl[i].d);

    // Both clients held: grants must alternate starting with client 0.
    aa[0] = 25'h0000100; aa[1] = 25'h0000200; ctl_busy = 2; n = 0;
    c0_req = 1'b1; c1_req = 1'b1; c0_addr = aa[0]; c1_addr = aa[1];
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk_sys);
      if (c0_ack || c1_ack) begin
        who = c1_ack ? 1 : 0;
        chk($sformatf("alt%0d_who", n), who, n % 2);
        chk($sformatf("alt%0d_data", n), {24'd0, who ? c1_data : c0_data}, {24'd0, mem_byte(aa[who])});
        aa[who] = aa[who] + 25'h11;
        if (who == 0) c0_addr = aa[0]; else c1_addr = aa[1];
        n++;
        if (n == 4) begin c0_req = 1'b0; c1_req = 1'b0; end
      end
    end
    c0_req = 1'b0; c1_req = 1'b0;
    chk("alt_count", n, 4);
    repeat (3) @(negedge clk_sys);

    // Download write with a client held off, plus an overrun byte.
    @(negedge clk_sys);
    dl_active = 1'b1; c1_req = 1'b1; c1_addr = 25'h0000333; ctl_busy = 3;
    @(negedge clk_sys);
    dl_wr = 1'b1; dl_addr = 25'h0000040; dl_data = 8'hA5;
    @(negedge clk_sys);
    chk("dl_wait_set", {31'd0, dl_wait}, 32'd1);
    dl_addr = 25'h0000041; dl_data = 8'h11;
    we_n = 0; we_k = -1; low_k = -1; rd_n = 0; ack_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_sys);
      if (k == 1) dl_wr = 1'b0;
      if (sd_we) begin
        we_n++;
        if (we_k < 0) begin
          we_k = k;
          chk("dl_we_addr", {7'd0, sd_addr}, 32'h40);
          chk("dl_we_data", {24'd0, sd_din}, 32'hA5);
        end
      end
      if (sd_rd) rd_n++;
      if (c1_ack) ack_n++;
      if (!dl_wait && low_k < 0) low_k = k;
    end
    chk("dl_we_latency", we_k, 1);
    chk("dl_we_count", we_n, 1);
    chk("dl_wait_release", low_k - we_k, 5);
    chk("dl_err_overrun", {31'd0, err}, 32'd1);
    chk("dl_no_client_rd", rd_n, 0);
    chk("dl_no_c1_ack", ack_n, 0);
    dl_active = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk_sys);
      if (c1_ack) begin
        got = 1;
        chk("dl_c1_data", {24'd0, c1_data}, 32'h48);
        c1_req = 1'b0;
      end
    end
    c1_req = 1'b0;
    chk("dl_c1_acked", got, 1);
    chk("err_sticky", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk_sys);

    do_reset();
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Controller never comes back: timeout forces an all-ones ack.
    ctl_stuck = 1'b1; ctl_busy = 2;
    c1_req = 1'b1; c1_addr = 25'h0000777;
    rd_k = -1; ack_k = -1;
    for (int k = 1; k <= 300 && ack_k < 0; k++) begin
      @(negedge clk_sys);
      if (sd_rd && rd_k < 0) rd_k = k;
      if (c0_ack || c1_ack) begin
        ack_k = k;
        chk("to_who", {30'd0, c1_ack, c0_ack}, 32'd2);
        chk("to_data", {24'd0, c1_data}, 32'hFF);
        c1_req = 1'b0;
      end
    end
    c1_req = 1'b0;
    chk("to_rd_seen", rd_k, 1);
    chk("to_delay", ack_k - rd_k, TO + 1);
    chk("to_err", {31'd0, err}, 32'd1);
    ctl_stuck = 1'b0;
    pref = 0;
    repeat (2) @(negedge clk_sys);
    do_read("after_to", 1'b1, 25'h0000123, 1'b0, 25'h0, 2, 0, 8'h5A);

    // Reset while waiting for the controller.
    ctl_busy = 10;
    c0_req = 1'b1; c0_addr = 25'h0000555;
    @(negedge clk_sys);
    chk("rst_rd_issued", {31'd0, sd_rd}, 32'd1);
    repeat (3) @(negedge clk_sys);
    reset = 1'b1; c0_req = 1'b0;
    @(negedge clk_sys);
    check_reset_outs("mid_reset");
    reset = 1'b0;
    ack_n = 0;
    repeat (15) begin
      @(negedge clk_sys);
      if (c0_ack || c1_ack) ack_n++;
    end
    chk("no_ack_after_reset", ack_n, 0);
    pref = 0;
    do_read("post_reset", 1'b1, 25'h000ABCD, 1'b0, 25'h0, 3, 0, 8'h1E);

    // Randomized client traffic against the arbitration rules.
    rand_mode = 1'b1;
    rq[0] = 1'b0; rq[1] = 1'b0; ra[0] = '0; ra[1] = '0;
    outst = 1'b0; og = 0; nack = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk_sys);
      if (sd_rd) begin
        if (rq[0] && rq[1]) g = pref;
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
        else g = -1;
        chk("rnd_rd_idle", {31'd0, outst}, 32'd0);
        chk("rnd_rd_has_req", {31'd0, (g >= 0)}, 32'd1);
        if (g >= 0) begin
          chk("rnd_rd_addr", {7'd0, sd_addr}, {7'd0, ra[g]});
          og = g; outst = 1'b1; pref = 1 - g;
        end
      end
      if (c0_ack || c1_ack) begin
        chk("rnd_ack_expected", {31'd0, outst}, 32'd1);
        if (outst) begin
          chk("rnd_ack_who", {30'd0, c1_ack, c0_ack}, (og == 1) ? 32'd2 : 32'd1);
          chk("rnd_ack_data", {24'd0, c1_ack ? c1_data : c0_data}, {24'd0, mem_byte(ra[og])});
          rq[og] = 1'b0;
        end
        outst = 1'b0; nack++;
      end
      if (cyc < 1000) begin
        for (int i = 0; i < 2; i++) begin
          if (!rq[i] && $urandom_range(0, 2) == 0) begin
            rq[i] = 1'b1;
            ra[i] = AW'($urandom);
          end
        end
      end
      c0_req = rq[0]; c0_addr = ra[0]; c1_req = rq[1]; c1_addr = ra[1];
      if (cyc >= 1000 && !outst && !rq[0] && !rq[1]) break;
    end
    c0_req = 1'b0; c1_req = 1'b0;
    chk("rnd_ack_count", {31'd0, (nack >= 40)}, 32'd1);
    chk("rnd_drained", {31'd0, outst}, 32'd0);
    repeat (3) @(negedge clk_sys);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single byte-wide SDRAM controller port between three requesters:
  - the ROM download writer (ioctl stream, with wait backpressure);
  - the background tile fetch client (client 0);
  - the sprite fetch client (client 1).
- Sits between the top-level emu wrapper / vball video fetch logic and the sdram controller.
- Replaces the direct download/gfx address mux.
- Sequences one SDRAM transaction at a time and returns read data with a one-cycle ack.

Parameters:
- AW, 25, address width on all ports.
- DW, 8, data width.
- TIMEOUT, 255, maximum cycles to wait for sd_ready after issue before aborting.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dl_active  in  1  ROM download in progress (ioctl_download & index 0)
- dl_wr  in  1  one-cycle download write strobe
- dl_addr  in  AW  download byte address
- dl_data  in  DW  download byte
- dl_wait  out  1  backpressure to hps_io (ioctl_wait)
- c0_req  in  1  tile client read request, level
- c0_addr  in  AW  tile client address
- c0_data  out  DW  tile read data, valid when c0_ack
- c0_ack  out  1  one-cycle completion pulse
- c1_req  in  1  sprite client read request, level
- c1_addr  in  AW  sprite client address
- c1_data  out  DW  sprite read data, valid when c1_ack
- c1_ack  out  1  one-cycle completion pulse
- sd_addr  out  AW  controller address
- sd_din  out  DW  controller write data
- sd_rd  out  1  one-cycle read command
- sd_we  out  1  one-cycle write command
- sd_dout  in  DW  controller read data
- sd_ready  in  1  controller idle / result valid
- err  out  1  sticky: timeout or dl_wr overrun

Behaviour:
- Reset values:
  - All outputs 0; c0_data/c1_data = 0.
  - FSM = IDLE; download holding register empty; rr pointer = client 0; err = 0.
- Reset mid-transaction: operation abandoned, no ack issued, download holding register cleared.
- Download capture:
  - dl_wr with holding register empty: latch addr/data, mark pending.
  - dl_wait = 1 from the next cycle until the cycle after the write's DONE.
  - dl_wr while pending: byte dropped, err set.
- Client handshake:
  - Client holds req high and addr stable until ack.
  - Ack is exactly one cycle; data valid only in that cycle.
  - Client must drop req or present a new address the cycle after ack.
- Priority at IDLE:
  - A pending download write always wins.
  - While dl_active = 1, client requests are never granted (held off, no ack).
  - Otherwise, single requester wins.
  - Both requesting: grant the client that was not served last (round-robin).
  - rr pointer updates only on client grant.
- FSM:
  - IDLE: wait for a grant candidate with sd_ready = 1. Register sd_addr/sd_din and the command, then go to ISSUE.
  - ISSUE: sd_rd or sd_we high for exactly this one cycle. Go to ACCEPT.
  - ACCEPT: wait for sd_ready = 0, then go to WAITRDY.
  - WAITRDY: wait for sd_ready = 1. On a read, capture sd_dout into the granted client's data register. Go to DONE.
  - DONE: pulse the granted client's ack (read) or clear the download pending flag (write). Return to IDLE.
- Latency:
  - Request seen at cycle t → sd_rd at t+1.
  - sd_ready returns high at cycle r → ack at r+1.
  - Minimum 4 cycles request to ack.
- Timeout:
  - Cycle counter (8 bits for the default) runs in ACCEPT and WAITRDY.
  - Reaching TIMEOUT forces DONE and sets err.
  - For a read, data = all ones and ack is still issued. For a write, the pending flag is cleared.
- sd_addr/sd_din hold their values outside ISSUE; sd_rd and sd_we are never both high.
- No combinational path from any input to sd_rd, sd_we or ack.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, ISSUE, ACCEPT, WAITRDY, DONE};
  - grant-id constants GNT_DL = 2'd2, GNT_C0 = 2'd0, GNT_C1 = 2'd1;
  - default TIMEOUT.
- One sub-module, sdram_rr_pick: combinational 2-way round-robin select, inputs req0/req1/last, outputs gnt_id/valid.
- Pointer register stays in the parent.

Test Plan:
- c0_req = 1, addr = 0x00123, controller model returns 0x5A with 3-cycle busy → exactly one sd_rd at t+1 with sd_addr = 0x00123; c0_ack one cycle with c0_data = 0x5A; c1_ack stays 0.
- c0 and c1 both held high for four transactions → grants alternate c0, c1, c0, c1; each ack carries its own address's data.
- dl_active = 1, dl_wr at addr 0x40, data 0xA5 while c1_req = 1 → sd_we with 0x40/0xA5 issued; dl_wait high until the cycle after DONE; c1 never acked while dl_active.
- Second dl_wr while dl_wait = 1 → that byte never reaches sd_we; err = 1 and stays 1.
- Controller holds sd_ready = 0 forever after a c1 read → after 255 cycles c1_ack with c1_data = 0xFF, err = 1, FSM returns to IDLE.
- reset asserted in WAITRDY → next cycle all outputs 0 and no ack; a fresh c0 request after reset completes normally.
